// File: rtl/fifo_pkg.sv
// Shared helpers for fifo_flex: width calculation and elaboration-time parameter checks.
package fifo_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << result) < value) begin
                result = result + 1;
            end
        end
        return result;
    endfunction

    function automatic bit depth_ok(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

    function automatic bit af_ok(input int af_thresh, input int depth);
        return (af_thresh >= 1) && (af_thresh <= depth);
    endfunction

    function automatic bit ae_ok(input int ae_thresh, input int depth);
        return (ae_thresh >= 0) && (ae_thresh <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_flex_ram.sv
// WIDTH x DEPTH storage for fifo_flex: one synchronous write port, one asynchronous read port.
module fifo_flex_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Show-ahead read: the head entry is visible without a read strobe.
    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_flex.sv
// Parametrised single-clock show-ahead FIFO with registered flags, thresholds, sticky errors and flush.
// Optional high-water-mark output enabled by defining FIFO_FLEX_HWM_EN.
module fifo_flex
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int AF_THRESH = 3,
    parameter int AE_THRESH = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       datain,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dataout,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [clog2(DEPTH):0]  count,
`ifdef FIFO_FLEX_HWM_EN
    output logic [clog2(DEPTH):0]  high_water,
`endif
    output logic                   overflow,
    output logic                   underflow
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("fifo_flex: DEPTH must be a power of two and at least 2");
    end
    if (!af_ok(AF_THRESH, DEPTH)) begin : g_bad_af
        $error("fifo_flex: AF_THRESH must be in 1..DEPTH");
    end
    if (!ae_ok(AE_THRESH, DEPTH)) begin : g_bad_ae
        $error("fifo_flex: AE_THRESH must be in 0..DEPTH-1");
    end

    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          full_reg;
    logic          empty_reg;
    logic          almost_full_reg;
    logic          almost_empty_reg;
    logic          overflow_reg;
    logic          underflow_reg;
    logic          push_ok;
    logic          pop_ok;
    logic          we;

    // A push into a full FIFO is only legal when the same cycle frees an entry.
    assign push_ok    = push & (~full_reg | pop);
    assign pop_ok     = pop & ~empty_reg;
    assign count_next = count_reg + CW'(push_ok) - CW'(pop_ok);
    assign we         = push_ok & ~rst & ~flush;

    fifo_flex_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr_reg),
        .wdata (datain),
        .raddr (rd_ptr_reg),
        .rdata (dataout)
    );

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr_reg       <= '0;
            wr_ptr_reg       <= '0;
            count_reg        <= '0;
            full_reg         <= 1'b0;
            empty_reg        <= 1'b1;
            almost_full_reg  <= (AF_THRESH == 0);
            almost_empty_reg <= 1'b1;
            if (rst) begin
                overflow_reg  <= 1'b0;
                underflow_reg <= 1'b0;
            end
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            if (push && full_reg && !pop) begin
                overflow_reg <= 1'b1;
            end
            if (pop && empty_reg) begin
                underflow_reg <= 1'b1;
            end
            count_reg        <= count_next;
            full_reg         <= (count_next == CW'(DEPTH));
            empty_reg        <= (count_next == '0);
            almost_full_reg  <= (count_next >= CW'(AF_THRESH));
            almost_empty_reg <= (count_next <= CW'(AE_THRESH));
        end
    end

`ifdef FIFO_FLEX_HWM_EN
    logic [CW-1:0] high_water_reg;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            high_water_reg <= '0;
        end else if (count_next > high_water_reg) begin
            high_water_reg <= count_next;
        end
    end

    assign high_water = high_water_reg;
`endif

    assign count        = count_reg;
    assign full         = full_reg;
    assign empty        = empty_reg;
    assign almost_full  = almost_full_reg;
    assign almost_empty = almost_empty_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

endmodule

// File: tb/tb_fifo_flex.sv
// Self-checking bench for fifo_flex: directed vector table plus randomized traffic against a queue model.
module tb_fifo_flex;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int AE    = 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             flush = 1'b0;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic [WIDTH-1:0] datain = '0;
    logic [WIDTH-1:0] dataout;
    logic             full, empty, almost_full, almost_empty, overflow, underflow;
    logic [2:0]       count;
`ifdef FIFO_FLEX_HWM_EN
    logic [2:0]       high_water;
    int               m_hw;
`endif

    fifo_flex #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .push         (push),
        .datain       (datain),
        .pop          (pop),
        .dataout      (dataout),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
`ifdef FIFO_FLEX_HWM_EN
        .high_water   (high_water),
`endif
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: contents as a queue, sticky errors as plain bits.
    logic [WIDTH-1:0] m_q[$];
    bit               m_ovf;
    bit               m_unf;

    typedef struct {
        bit         rst;
        bit         flush;
        bit         push;
        bit         pop;
        logic [7:0] din;
        int         exp_count;
        bit         chk_dout;
        logic [7:0] exp_dout;
        bit         exp_ovf;
        bit         exp_unf;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_update(input bit r, input bit f, input bit pu, input bit po,
                                input logic [7:0] d);
        bit was_full, was_empty, push_ok, pop_ok;
        if (r) begin
            m_q.delete();
            m_ovf = 0;
            m_unf = 0;
`ifdef FIFO_FLEX_HWM_EN
            m_hw = 0;
`endif
        end else if (f) begin
            m_q.delete();
`ifdef FIFO_FLEX_HWM_EN
            m_hw = 0;
`endif
        end else begin
            was_full  = (m_q.size() == DEPTH);
            was_empty = (m_q.size() == 0);
            push_ok   = pu && (!was_full || po);
            pop_ok    = po && !was_empty;
            if (pu && was_full && !po) m_ovf = 1;
            if (po && was_empty) m_unf = 1;
            if (pop_ok) void'(m_q.pop_front());
            if (push_ok) m_q.push_back(d);
`ifdef FIFO_FLEX_HWM_EN
            if (m_q.size() > m_hw) m_hw = m_q.size();
`endif
        end
    endtask

    task automatic model_check();
        int n;
        n = m_q.size();
        chk("count", int'(count), n);
        chk("empty", int'(empty), int'(n == 0));
        chk("full", int'(full), int'(n == DEPTH));
        chk("almost_full", int'(almost_full), int'(n >= AF));
        chk("almost_empty", int'(almost_empty), int'(n <= AE));
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("underflow", int'(underflow), int'(m_unf));
        if (n != 0) chk("dataout", int'(dataout), int'(m_q[0]));
`ifdef FIFO_FLEX_HWM_EN
        chk("high_water", int'(high_water), m_hw);
`endif
    endtask

    // One clock: drive at negedge, sample 1 time unit after the rising edge.
    task automatic step(input bit r, input bit f, input bit pu, input bit po,
                        input logic [7:0] d);
        @(negedge clk);
        rst = r; flush = f; push = pu; pop = po; datain = d;
        @(posedge clk);
        #1;
        model_update(r, f, pu, po, d);
        $display("cyc rst=%0b flush=%0b push=%0b pop=%0b din=%02h -> count=%0d dout=%02h ovf=%0b unf=%0b",
                 r, f, pu, po, d, count, dataout, overflow, underflow);
        model_check();
    endtask

    task automatic addv(input bit r, input bit f, input bit pu, input bit po, input logic [7:0] d,
                        input int c, input bit cd, input logic [7:0] ed, input bit eo, input bit eu);
        vec_t v;
        v = '{r, f, pu, po, d, c, cd, ed, eo, eu};
        vecs.push_back(v);
    endtask

    initial begin
        // Reset for two cycles
        addv(1,0,0,0,8'h00, 0,0,8'h00, 0,0);
        addv(1,0,0,0,8'h00, 0,0,8'h00, 0,0);
        // Fill, then drain in order
        addv(0,0,1,0,8'h11, 1,1,8'h11, 0,0);
        addv(0,0,1,0,8'h22, 2,1,8'h11, 0,0);
        addv(0,0,1,0,8'h33, 3,1,8'h11, 0,0);
        addv(0,0,1,0,8'h44, 4,1,8'h11, 0,0);
        addv(0,0,0,1,8'h00, 3,1,8'h22, 0,0);
        addv(0,0,0,1,8'h00, 2,1,8'h33, 0,0);
        addv(0,0,0,1,8'h00, 1,1,8'h44, 0,0);
        addv(0,0,0,1,8'h00, 0,0,8'h00, 0,0);
        // Overflow on full, then push+pop while full
        addv(0,0,1,0,8'hA1, 1,1,8'hA1, 0,0);
        addv(0,0,1,0,8'hA2, 2,1,8'hA1, 0,0);
        addv(0,0,1,0,8'hA3, 3,1,8'hA1, 0,0);
        addv(0,0,1,0,8'hA4, 4,1,8'hA1, 0,0);
        addv(0,0,1,0,8'h55, 4,1,8'hA1, 1,0);
        addv(0,0,1,1,8'h66, 4,1,8'hA2, 1,0);
        addv(0,0,0,1,8'h00, 3,1,8'hA3, 1,0);
        addv(0,0,0,1,8'h00, 2,1,8'hA4, 1,0);
        addv(0,0,0,1,8'h00, 1,1,8'h66, 1,0);
        addv(0,0,0,1,8'h00, 0,0,8'h00, 1,0);
        // Underflow on empty, then push+pop while empty
        addv(0,0,0,1,8'h00, 0,0,8'h00, 1,1);
        addv(0,0,1,1,8'h77, 1,1,8'h77, 1,1);
        addv(0,0,0,1,8'h00, 0,0,8'h00, 1,1);
        // Flush keeps the sticky error flags
        addv(0,1,0,0,8'h00, 0,0,8'h00, 1,1);
        addv(0,0,1,0,8'hB1, 1,1,8'hB1, 1,1);
        addv(0,0,1,0,8'hB2, 2,1,8'hB1, 1,1);
        addv(0,0,1,0,8'hB3, 3,1,8'hB1, 1,1);
`ifdef FIFO_FLEX_HWM_EN
        addv(0,0,0,0,8'h00, 3,1,8'hB1, 1,1);
`endif
        addv(0,1,1,0,8'hCC, 0,0,8'h00, 1,1);

        for (int i = 0; i < vecs.size(); i++) begin
`ifdef FIFO_FLEX_HWM_EN
            if (i == vecs.size() - 2) chk("hwm_before_flush", int'(high_water), 3);
`endif
            step(vecs[i].rst, vecs[i].flush, vecs[i].push, vecs[i].pop, vecs[i].din);
            chk($sformatf("vec%0d_count", i), int'(count), vecs[i].exp_count);
            chk($sformatf("vec%0d_overflow", i), int'(overflow), int'(vecs[i].exp_ovf));
            chk($sformatf("vec%0d_underflow", i), int'(underflow), int'(vecs[i].exp_unf));
            if (vecs[i].chk_dout)
                chk($sformatf("vec%0d_dataout", i), int'(dataout), int'(vecs[i].exp_dout));
        end
`ifdef FIFO_FLEX_HWM_EN
        chk("hwm_after_flush", int'(high_water), 0);
`endif

        // Pointer wrap: push/pop pairs at varying occupancy, errors cleared first
        step(1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 10; i++) begin
            if (m_q.size() < 3) step(0, 0, 1, 0, 8'(8'h80 + i));
            step(0, 0, 1, 1, 8'(8'hC0 + i));
            if (i % 3 == 2) begin
                while (m_q.size() > 0) step(0, 0, 0, 1, 8'h00);
            end
        end
        chk("wrap_no_overflow", int'(overflow), 0);
        chk("wrap_no_underflow", int'(underflow), 0);

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 400; i++) begin
            bit r, f;
            r = ($urandom_range(0, 99) == 0);
            f = ($urandom_range(0, 39) == 0);
            step(r, f, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
        end

        @(negedge clk);
        rst = 0; flush = 0; push = 0; pop = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
